sram_mbist: RTL and testbench
=============================

# sram_mbist

Built-in self-test and access mux sitting directly upstream of the 8x8 single-port SRAM (`sp_sram`). When idle it passes the functional write/read port straight through to the SRAM. On `start` it takes ownership of the SRAM port and runs a March C- sequence, checking every read against the expected background. It reports pass/fail, the first failing address and an error count.

## Interface
Parameters:
- `DATA_W`, 8: SRAM word width.
- `ADDR_W`, 3: SRAM address width; `DEPTH = 2**ADDR_W`.

Ports:
- `clk`  in  1: single clock; all state updates on rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `start`  in  1: begin test; sampled only when `busy`=0.
- `func_din`  in  DATA_W: functional write data.
- `func_addr`  in  ADDR_W: functional address.
- `func_wr_en`  in  1: functional write enable.
- `mem_dout`  in  DATA_W: SRAM read data; registered, valid the cycle after the address is presented with `wr_en`=0.
- `mem_din`  out  DATA_W: to SRAM `din`.
- `mem_addr`  out  ADDR_W: to SRAM `addr`.
- `mem_wr_en`  out  1: to SRAM `wr_en`.
- `busy`  out  1: test running; functional port disconnected.
- `done`  out  1: test finished; held until next `start` or reset.
- `pass`  out  1: valid when `done`=1; 1 = no mismatches.
- `fail_addr`  out  ADDR_W: address of first mismatch.
- `err_cnt`  out  8: mismatch count, saturates at 255.

## Operation
- `busy`=0: `mem_din`/`mem_addr`/`mem_wr_en` = `func_*` combinationally.
- `busy`=1: `mem_*` are driven from FSM registers only. Functional inputs are ignored.
- March elements (bg0 = 0x00, bg1 = all ones):
  - E0 ⇑ w0
  - E1 ⇑ r0,w1
  - E2 ⇑ r1,w0
  - E3 ⇓ r0,w1
  - E4 ⇓ r1,w0
  - E5 ⇓ r0
- FSM states:
  - IDLE: `start` → INIT, addr=0, clear `done`/`pass`/`err_cnt`/`fail_addr`.
  - INIT (E0): write bg0 at addr, 1 cycle/address. At last address → RD, elem=1, addr=0.
  - RD: `mem_wr_en`=0, `mem_addr`=addr → CMP.
  - CMP: compare `mem_dout` against the expected value. For E1–E4, write the inverted background at the same addr this cycle; E5 does no write. Then advance addr (up for E1/E2, down for E3–E5). At the element's last address, go to the next element; ⇓ elements start at DEPTH-1. E5 last → DONE.
  - DONE: `busy`=0, `done`=1, `pass` = (`err_cnt`==0). `start` → INIT (restart).
- On a mismatch: `err_cnt`++ (saturating). If this is the first mismatch, capture `fail_addr`.
- Address counter never wraps mid-element. End of element is detected at `DEPTH-1` (⇑) or `0` (⇓).

## Timing
- Reset values: all registered outputs 0 and FSM in IDLE. `mem_*` then follow `func_*`.
- `start` sampled at edge N → `busy`=1 after N; first SRAM write is committed at edge N+1.
- Total run is 11·DEPTH cycles (88 at default). `done`=1, `busy`=0 after edge N+88.
- First E1 compare occurs at edge N+10. The E1 compare for address a occurs at edge N+10+2a.
- `start` while `busy`=1 is ignored. `start` held high in DONE restarts on the next edge.
- `rst` mid-run: outputs clear immediately (async) and `mem_wr_en` drops to follow `func_wr_en`. No partial result is retained.

## Configuration
- `MBIST_STOP_ON_FAIL_EN` defined: the first mismatch moves the FSM from CMP to DONE on that edge. No write occurs in that CMP cycle. Result is `err_cnt`=1, `pass`=0.
- Macro undefined: the full sequence always runs and `err_cnt` accumulates.

## Structure
- `sram_mbist_pkg`: FSM state enum (IDLE, INIT, RD, CMP, DONE), element index constants E0–E5, background constants, per-element direction/expected/write lookup functions.
- Sub-module `sram_mbist_addr_gen`: loadable up/down counter with `first`/`last` flags.

## Test plan
- Reset asserted → `busy`/`done`/`pass`/`err_cnt`/`fail_addr` = 0. `func_addr`=3, `func_din`=0xA5, `func_wr_en`=1 appear on `mem_*` in the same cycle.
- Fault-free SRAM model, `start` pulse → `busy` for 88 cycles, then `done`=1, `pass`=1, `err_cnt`=0.
- Bit 0 stuck-at-1 at address 5, macro undefined → `done` at N+88, `pass`=0, `fail_addr`=5, `err_cnt`=3.
- Same fault with `MBIST_STOP_ON_FAIL_EN` → `done` after edge N+20, `err_cnt`=1, `fail_addr`=5, `mem_wr_en`=0 in that cycle.
- `start` re-pulsed at cycle 30 of a run is ignored (`done` still at N+88). A `start` in DONE clears results and reruns.
- `rst` pulsed at cycle 40 → outputs 0 immediately. A new `start` then completes with `pass`=1.

Source files
------------

// File: rtl/sram_mbist_pkg.sv
// Shared types and March C- element tables for the SRAM BIST controller.
package sram_mbist_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_INIT = 3'd1,
    S_RD   = 3'd2,
    S_CMP  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [2:0] E0 = 3'd0;
  localparam logic [2:0] E1 = 3'd1;
  localparam logic [2:0] E2 = 3'd2;
  localparam logic [2:0] E3 = 3'd3;
  localparam logic [2:0] E4 = 3'd4;
  localparam logic [2:0] E5 = 3'd5;

  // Backgrounds are single bits replicated across the data word.
  localparam logic BG0 = 1'b0;
  localparam logic BG1 = 1'b1;

  typedef struct packed {
    state_t     state;
    logic [2:0] elem;
    logic       addr_first;
    logic       addr_last;
  } dbg_t;

  function automatic logic elem_is_down(input logic [2:0] e);
    return (e == E3) || (e == E4) || (e == E5);
  endfunction

  function automatic logic elem_exp_bg(input logic [2:0] e);
    return ((e == E2) || (e == E4)) ? BG1 : BG0;
  endfunction

  function automatic logic elem_has_write(input logic [2:0] e);
    return (e == E0) || (e == E1) || (e == E2) || (e == E3) || (e == E4);
  endfunction

  function automatic logic elem_wr_bg(input logic [2:0] e);
    return ((e == E1) || (e == E3)) ? BG1 : BG0;
  endfunction

endpackage

// File: rtl/sram_mbist_addr_gen.sv
// Loadable up/down address counter with first/last flags for the active direction.
module sram_mbist_addr_gen #(
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              step,
  input  logic              down,
  output logic [ADDR_W-1:0] addr,
  output logic              first,
  output logic              last
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr <= '0;
    end else if (load) begin
      addr <= load_val;
    end else if (step) begin
      addr <= down ? addr - 1'b1 : addr + 1'b1;
    end
  end

  assign first = down ? (addr == {ADDR_W{1'b1}}) : (addr == '0);
  assign last  = down ? (addr == '0) : (addr == {ADDR_W{1'b1}});

endmodule

// File: rtl/sram_mbist.sv
// March C- BIST and functional access mux in front of a single-port SRAM.
// Build option: MBIST_STOP_ON_FAIL_EN ends the run at the first mismatch.
module sram_mbist
  import sram_mbist_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] func_din,
  input  logic [ADDR_W-1:0] func_addr,
  input  logic              func_wr_en,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [DATA_W-1:0] mem_din,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr_en,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [7:0]        err_cnt,
  output dbg_t              dbg
);

  state_t            state, state_nxt;
  logic [2:0]        elem, elem_nxt;
  logic              ag_load, ag_step, ag_down;
  logic [ADDR_W-1:0] ag_load_val, addr;
  logic              addr_first, addr_last;
  logic              bist_wr;
  logic [DATA_W-1:0] bist_din;
  logic              mismatch, stop_hit, start_ok;

  sram_mbist_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .load     (ag_load),
    .load_val (ag_load_val),
    .step     (ag_step),
    .down     (ag_down),
    .addr     (addr),
    .first    (addr_first),
    .last     (addr_last)
  );

  // start/done handshake: start is accepted only while not busy; done holds until the next accepted start.
  assign start_ok = start && ((state == S_IDLE) || (state == S_DONE));
  assign mismatch = (state == S_CMP) && (mem_dout != {DATA_W{elem_exp_bg(elem)}});

`ifdef MBIST_STOP_ON_FAIL_EN
  assign stop_hit = mismatch;
`else
  assign stop_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      elem  <= E0;
    end else begin
      state <= state_nxt;
      elem  <= elem_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    elem_nxt    = elem;
    ag_load     = 1'b0;
    ag_load_val = '0;
    ag_step     = 1'b0;
    ag_down     = elem_is_down(elem);
    bist_wr     = 1'b0;
    bist_din    = '0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt = S_INIT;
          elem_nxt  = E0;
          ag_load   = 1'b1;
        end
      end
      S_INIT: begin
        bist_wr  = 1'b1;
        bist_din = {DATA_W{BG0}};
        if (addr_last) begin
          state_nxt = S_RD;
          elem_nxt  = E1;
          ag_load   = 1'b1;
        end else begin
          ag_step = 1'b1;
        end
      end
      S_RD: state_nxt = S_CMP;
      S_CMP: begin
        if (stop_hit) begin
          state_nxt = S_DONE;
        end else begin
          bist_wr  = elem_has_write(elem);
          bist_din = {DATA_W{elem_wr_bg(elem)}};
          if (!addr_last) begin
            ag_step   = 1'b1;
            state_nxt = S_RD;
          end else if (elem == E5) begin
            state_nxt = S_DONE;
          end else begin
            // Next element restarts at the low or high end depending on its direction.
            elem_nxt    = elem + 3'd1;
            state_nxt   = S_RD;
            ag_load     = 1'b1;
            ag_load_val = elem_is_down(elem + 3'd1) ? {ADDR_W{1'b1}} : '0;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt   <= '0;
      fail_addr <= '0;
    end else if (start_ok) begin
      err_cnt   <= '0;
      fail_addr <= '0;
    end else if (mismatch) begin
      if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      if (err_cnt == 8'd0) fail_addr <= addr;
    end
  end

  assign busy = (state == S_INIT) || (state == S_RD) || (state == S_CMP);
  assign done = (state == S_DONE);
  assign pass = done && (err_cnt == 8'd0);

  assign mem_din   = busy ? bist_din : func_din;
  assign mem_addr  = busy ? addr : func_addr;
  assign mem_wr_en = busy ? bist_wr : func_wr_en;

  always_comb begin
    dbg.state      = state;
    dbg.elem       = elem;
    dbg.addr_first = addr_first;
    dbg.addr_last  = addr_last;
  end

endmodule

// File: tb/tb_sram_mbist.sv
// Bench for sram_mbist: SRAM model with an injectable stuck-at fault and a March C- reference.
module tb_sram_mbist;
  import sram_mbist_pkg::*;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 8;
`ifdef MBIST_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  // March C- as a table: direction, read expectation (-1 none), write value (-1 none).
  localparam int DOWN_T [6] = '{0, 0, 0, 1, 1, 1};
  localparam int RD_T   [6] = '{-1, 0, 1, 0, 1, 0};
  localparam int WR_T   [6] = '{0, 1, 0, 1, 0, -1};

  logic              clk, rst, start;
  logic [DATA_W-1:0] func_din, mem_dout, mem_din;
  logic [ADDR_W-1:0] func_addr, mem_addr, fail_addr;
  logic              func_wr_en, mem_wr_en, busy, done, pass;
  logic [7:0]        err_cnt;
  dbg_t              dbg;

  int n_cmp = 0;
  int n_err = 0;

  sram_mbist #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .func_din(func_din), .func_addr(func_addr), .func_wr_en(func_wr_en),
    .mem_dout(mem_dout), .mem_din(mem_din), .mem_addr(mem_addr), .mem_wr_en(mem_wr_en),
    .busy(busy), .done(done), .pass(pass), .fail_addr(fail_addr), .err_cnt(err_cnt),
    .dbg(dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model with one optional stuck-at fault applied on read
  logic [DATA_W-1:0] sram [DEPTH];
  logic              f_en;
  int                f_addr;
  logic [DATA_W-1:0] f_mask, f_val;

  function automatic logic [DATA_W-1:0] faulty(input logic [DATA_W-1:0] v, input int a);
    if (f_en && a == f_addr) return (v & ~f_mask) | (f_val & f_mask);
    return v;
  endfunction

  always @(posedge clk) begin
    if (mem_wr_en) sram[mem_addr] <= mem_din;
    else mem_dout <= faulty(sram[mem_addr], int'(mem_addr));
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference: walk the march table over a plain array
  task automatic model(output int e_err, output int e_fa, output int e_cyc);
    logic [DATA_W-1:0] m [DEPTH];
    logic [DATA_W-1:0] got, exp;
    int reads, first_k, a;
    bit halted;
    e_err = 0; e_fa = 0; reads = 0; first_k = -1; halted = 0;
    for (int el = 0; el < 6; el++) begin
      for (int i = 0; i < DEPTH; i++) begin
        a = (DOWN_T[el] != 0) ? DEPTH - 1 - i : i;
        if (!halted && RD_T[el] >= 0) begin
          got = faulty(m[a], a);
          exp = (RD_T[el] != 0) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
          if (got != exp) begin
            e_err++;
            if (first_k < 0) begin
              first_k = reads;
              e_fa = a;
            end
            if (STOP) halted = 1;
          end
          reads++;
        end
        if (!halted && WR_T[el] >= 0)
          m[a] = (WR_T[el] != 0) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
      end
    end
    e_cyc = DEPTH + 2 * reads;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_test(input string tag, input bit pulse_mid);
    int e_err, e_fa, e_cyc, cyc;
    model(e_err, e_fa, e_cyc);
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy_start"}, 32'(busy), 32'd1);
    check({tag, "_cleared"}, {23'd0, done, err_cnt}, 32'd0);
    cyc = 0;
    while (!done && cyc < 200) begin
      func_din   = DATA_W'($urandom);
      func_addr  = ADDR_W'($urandom);
      func_wr_en = 1'($urandom_range(0, 1));
      start      = pulse_mid && (cyc == 30);
      if (cyc == e_cyc - 1) begin
        check({tag, "_last_wr_en"}, 32'(mem_wr_en), 32'd0);
        check({tag, "_last_busy"}, 32'(busy), 32'd1);
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    check({tag, "_cycles"}, 32'(cyc), 32'(e_cyc));
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    check({tag, "_pass"}, 32'(pass), 32'(e_err == 0));
    check({tag, "_err_cnt"}, 32'(err_cnt), 32'(e_err));
    check({tag, "_fail_addr"}, 32'(fail_addr), 32'(e_fa));
  endtask

  initial begin
    f_en = 1'b0; f_addr = 0; f_mask = '0; f_val = '0;
    for (int i = 0; i < DEPTH; i++) sram[i] = DATA_W'($urandom);
    rst = 1'b1; start = 1'b0;
    func_addr = 3'd3; func_din = 8'hA5; func_wr_en = 1'b1;
    #2;
    check("rst_outs", {20'd0, busy, done, pass, fail_addr, err_cnt}, 32'd0);
    check("rst_state", 32'(dbg.state), 32'(S_IDLE));
    check("rst_mem_addr", 32'(mem_addr), 32'd3);
    check("rst_mem_din", 32'(mem_din), 32'hA5);
    check("rst_mem_wr", 32'(mem_wr_en), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    func_wr_en = 1'b0;
    tick();

    run_test("clean", 1'b0);

    f_en = 1'b1; f_addr = 5; f_mask = 8'h01; f_val = 8'h01;
    run_test("sa1_a5", 1'b0);

    f_en = 1'b0;
    run_test("restart_mid", 1'b1);

    for (int r = 0; r < 6; r++) begin
      f_en   = 1'($urandom_range(0, 3) != 0);
      f_addr = $urandom_range(0, DEPTH - 1);
      f_mask = DATA_W'(1) << $urandom_range(0, DATA_W - 1);
      f_val  = $urandom_range(0, 1) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
      run_test($sformatf("rand%0d", r), 1'b0);
    end

    // reset in the middle of a run
    f_en = 1'b1; f_addr = 2; f_mask = 8'h80; f_val = 8'h00;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (40) tick();
    func_addr = 3'd6; func_din = 8'h3C; func_wr_en = 1'b1;
    rst = 1'b1;
    #1;
    check("midrst_outs", {20'd0, busy, done, pass, fail_addr, err_cnt}, 32'd0);
    check("midrst_mem_wr", 32'(mem_wr_en), 32'd1);
    check("midrst_mem_addr", 32'(mem_addr), 32'd6);
    @(posedge clk);
    #1;
    rst = 1'b0;
    func_wr_en = 1'b0;
    f_en = 1'b0;
    tick();
    run_test("after_rst", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
